// File: rtl/frame_pixel_writer.sv
// frame_pixel_writer
//   Write-side stage of the dual-clock pixel FIFO (clk_sys domain). Accepts the
//   composed pixel stream (valid/ready) and writes exactly H_RES*V_RES pixels per
//   frame into the FIFO, holding the write while wrfull is asserted. Pulses
//   new_frame for one cycle at each frame start.
//
//   Optional build macro: TEST_PATTERN_EN
//     Adds the pattern_sel input. A frame started with pattern_sel=1 is fed by an
//     internal always-valid generator of 8 vertical colour bars (H_RES/8 wide,
//     H_RES must be a multiple of 8); src_ready stays 0 for that frame.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   enable        lets a new frame start (looked at only in IDLE)
//   src_data/src_valid/src_ready   pixel stream from the composer
//   pattern_sel   (TEST_PATTERN_EN only) select the internal bar generator
//   fifo_data/fifo_wrreq/fifo_wrfull  FIFO write port, wrreq registered
//   pix_x, pix_y  coordinates of the next pixel to accept
//   new_frame     one-cycle pulse at frame start
//   frame_count   number of completed frames, wraps
module frame_pixel_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PIX_W-1:0] src_data,
    input  logic             src_valid,
`ifdef TEST_PATTERN_EN
    input  logic             pattern_sel,
`endif
    output logic             src_ready,
    output logic [PIX_W-1:0] fifo_data,
    output logic             fifo_wrreq,
    input  logic             fifo_wrfull,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             new_frame,
    output logic [15:0]      frame_count
);

    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    state_t           state, state_next;
    logic             out_valid;
    logic             write_done;
    logic             reg_free;
    logic             accept;
    logic             last_pix;
    logic             use_pattern;
    logic [PIX_W-1:0] load_data;

    // The output register can take a new pixel when it is empty or its
    // current contents leave for the FIFO on this same edge.
    assign write_done = out_valid && !fifo_wrfull;
    assign reg_free   = !out_valid || write_done;
    assign last_pix   = (pix_x == 10'(H_RES - 1)) && (pix_y == 10'(V_RES - 1));
    assign fifo_wrreq = out_valid;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_RES / 8;

    logic       pattern_q;
    logic [2:0] bar_idx;

    always_ff @(posedge clk) begin
        if (rst)
            pattern_q <= 1'b0;
        else if (state == START)
            pattern_q <= pattern_sel;
    end

    assign use_pattern = pattern_q;
    assign bar_idx     = 3'(pix_x / 10'(BAR_W));

    always_comb begin
        load_data = '0;
        if (pattern_q) begin
            case (bar_idx)
                3'd0: load_data = PIX_W'(24'hFFFFFF);
                3'd1: load_data = PIX_W'(24'hFFFF00);
                3'd2: load_data = PIX_W'(24'h00FFFF);
                3'd3: load_data = PIX_W'(24'h00FF00);
                3'd4: load_data = PIX_W'(24'hFF00FF);
                3'd5: load_data = PIX_W'(24'hFF0000);
                3'd6: load_data = PIX_W'(24'h0000FF);
                default: load_data = PIX_W'(24'h000000);
            endcase
        end else begin
            load_data = src_data;
        end
    end
`else
    assign use_pattern = 1'b0;
    assign load_data   = src_data;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = START;
            START:   state_next = STREAM;
            STREAM:  if (accept && last_pix) state_next = DRAIN;
            DRAIN:   if (reg_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs / handshake
    always_comb begin
        new_frame = (state == START);
        src_ready = (state == STREAM) && reg_free && !use_pattern;
        accept    = (state == STREAM) && reg_free && (use_pattern || src_valid);
    end

    // Output register: loading wins over a draining write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            fifo_data <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            fifo_data <= load_data;
        end else if (write_done) begin
            out_valid <= 1'b0;
        end
    end

    // Pixel position of the next accept; wraps to (0,0) after the last pixel.
    always_ff @(posedge clk) begin
        if (rst || state == START) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (accept) begin
            if (pix_x == 10'(H_RES - 1)) begin
                pix_x <= '0;
                pix_y <= (pix_y == 10'(V_RES - 1)) ? '0 : pix_y + 10'd1;
            end else begin
                pix_x <= pix_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            frame_count <= '0;
        else if (state == DRAIN && reg_free)
            frame_count <= frame_count + 16'd1;
    end

endmodule

// File: tb/tb_frame_pixel_writer.sv
module tb_frame_pixel_writer;

    localparam int H = 32;
    localparam int V = 6;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [23:0] fifo_data;
    logic        fifo_wrreq;
    logic        fifo_wrfull = 1'b0;
    logic [9:0]  pix_x, pix_y;
    logic        new_frame;
    logic [15:0] frame_count;
`ifdef TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    frame_pixel_writer #(.H_RES(H), .V_RES(V), .PIX_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .src_data    (src_data),
        .src_valid   (src_valid),
`ifdef TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .src_ready   (src_ready),
        .fifo_data   (fifo_data),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_wrfull (fifo_wrfull),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .new_frame   (new_frame),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus controls (written by the main sequence only)
    logic valid_en   = 1'b0;
    logic rand_mode  = 1'b0;
    int   stall_until = 0;

    // Reference model state (written by the monitor only)
    logic [23:0] exp_q[$];
    int   acc_idx = 0;
    int   written = 0;
    int   frames_done = 0;
    logic in_frame = 1'b0;
    logic pat_frame = 1'b0;
    logic acc_next = 1'b0;
    logic prev_stall = 1'b0;
    logic [23:0] prev_data = '0;
    int   cyc = 0;

    logic [23:0] bar_colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Input driver: inputs change 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (acc_next) src_data = src_data + 24'd1;
        src_valid   = rand_mode ? ($urandom_range(0, 1) == 1) : valid_en;
        fifo_wrfull = (cyc < stall_until) || (rand_mode && ($urandom_range(0, 1) == 1));
    end

    // Monitor: at the falling edge the inputs are settled, so handshakes seen
    // here are exactly those that take effect on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_idx     = 0;
            written     = 0;
            frames_done = 0;
            in_frame    = 1'b0;
            pat_frame   = 1'b0;
            acc_next    = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_wrreq_held", 32'(fifo_wrreq), 32'd1);
                check("stall_data_held", 32'(fifo_data), 32'(prev_data));
            end
            if (fifo_wrreq && fifo_wrfull)
                check("no_accept_in_stall", 32'(src_ready), 32'd0);
            prev_stall = fifo_wrreq && fifo_wrfull;
            prev_data  = fifo_data;

            if (new_frame) begin
                check("nf_prev_frame_done", 32'(in_frame), 32'd0);
                check("nf_pix_x", 32'(pix_x), 32'd0);
                check("nf_pix_y", 32'(pix_y), 32'd0);
                check("nf_frame_count", 32'(frame_count), 32'(frames_done));
                in_frame = 1'b1;
`ifdef TEST_PATTERN_EN
                pat_frame = pattern_sel;
`endif
            end

            if (pat_frame)
                check("pattern_ready_low", 32'(src_ready), 32'd0);

            acc_next = src_valid && src_ready;
            if (acc_next) begin
                check("accept_in_frame", 32'(in_frame), 32'd1);
                check("pix_x", 32'(pix_x), 32'(acc_idx % H));
                check("pix_y", 32'(pix_y), 32'(acc_idx / H));
                exp_q.push_back(src_data);
                acc_idx++;
                if (acc_idx == N) begin
                    acc_idx  = 0;
                    in_frame = 1'b0;
                end
            end

            if (fifo_wrreq && !fifo_wrfull) begin
                if (pat_frame) begin
                    check("pattern_pixel", 32'(fifo_data), 32'(bar_colors[(written % H) / (H / 8)]));
                end else begin
                    check("write_has_source", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0)
                        check("write_data_order", 32'(fifo_data), 32'(exp_q.pop_front()));
                end
                written++;
                if (written == N) begin
                    written = 0;
                    frames_done++;
                    if (pat_frame) begin
                        in_frame  = 1'b0;
                        pat_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_reached", 32'(frames_done >= target), 32'd1);
        @(negedge clk);
        check("frame_count", 32'(frame_count), 32'(target));
    endtask

    task automatic wait_nf(input int budget);
        int n = 0;
        while (!new_frame && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("new_frame_seen", 32'(new_frame), 32'd1);
    endtask

    initial begin
        int n;

        // T1: reset values, then first new_frame two cycles after release
        enable = 1'b1;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_data", 32'(fifo_data), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_pix_y", 32'(pix_y), 32'd0);
        check("rst_new_frame", 32'(new_frame), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t1_nf_before", 32'(new_frame), 32'd0);
        @(negedge clk);
        check("t1_nf_pulse", 32'(new_frame), 32'd1);
        @(negedge clk);
        check("t1_nf_single", 32'(new_frame), 32'd0);

        // T2: continuous source, no backpressure, one full frame
        valid_en = 1'b1;
        wait_frames(1, 4 * N);
        wait_nf(5);

        // T3: 10-cycle wrfull stall mid-line with a pixel in the register
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pix_x == 10'd7 && fifo_wrreq) && n < 4 * N);
        check("t3_trigger", 32'(pix_x), 32'd7);
        stall_until = cyc + 11;
        repeat (5) @(negedge clk);
        check("t3_wrreq_mid_stall", 32'(fifo_wrreq), 32'd1);
        check("t3_ready_mid_stall", 32'(src_ready), 32'd0);
        wait_frames(2, 4 * N);

        // T4: random valid / wrfull for three frames
        rand_mode = 1'b1;
        wait_frames(5, 40 * N);
        rand_mode = 1'b0;

        // T5: reset in the middle of a frame
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pix_x == 10'd5 && pix_y == 10'd2 && src_ready) && n < 4 * N);
        check("t5_trigger_y", 32'(pix_y), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_wrreq_after_rst", 32'(fifo_wrreq), 32'd0);
        check("t5_pix_x_after_rst", 32'(pix_x), 32'd0);
        check("t5_fc_after_rst", 32'(frame_count), 32'd0);
        rst = 1'b0;
        wait_nf(5);
        wait_frames(1, 4 * N);

`ifdef TEST_PATTERN_EN
        // T6: internal colour bars
        pattern_sel = 1'b1;
        wait_frames(3, 8 * N);
        pattern_sel = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
